// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU and the UART program loader.
// Each grant runs IDLE -> ACCESS (memory cycle) -> RESP (ack pulse) and returns to IDLE.
module mem_arbiter #(
   parameter int ADDR_W = 14
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_ack,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_err,
   input  logic              ldr_req,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [31:0]       ldr_wdata,
   output logic              ldr_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              gnt_ldr_q, gnt_ldr_d;
   logic              last_ldr_q, last_ldr_d;
   logic              ok_q, ok_d;
   logic              rd_q, rd_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              ldr_ack_q, ldr_ack_d;
   logic              cpu_err_q, cpu_err_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic              pick_ldr_s;
   logic              cpu_ok_s;

   // A CPU address is usable only if word-aligned and inside the data memory.
   function automatic logic addr_ok(input logic [31:0] addr);
      logic [31:0] hi;
      hi = addr >> (ADDR_W + 2);
      return (hi == 32'd0) && (addr[1:0] == 2'b00);
   endfunction

   // Next-state, grant selection and registered-output computation.
   always_comb begin
      state_d     = state_q;
      gnt_ldr_d   = gnt_ldr_q;
      last_ldr_d  = last_ldr_q;
      ok_d        = ok_q;
      rd_d        = rd_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_ack_d   = 1'b0;
      ldr_ack_d   = 1'b0;
      cpu_err_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      // On a tie the loader wins only if the CPU held the last grant.
      pick_ldr_s  = ldr_req & (~cpu_req | ~last_ldr_q);
      cpu_ok_s    = addr_ok(cpu_addr);

      case (state_q)
         IDLE: begin
            if (cpu_req | ldr_req) begin
               state_d    = ACCESS;
               gnt_ldr_d  = pick_ldr_s;
               last_ldr_d = pick_ldr_s;
               if (pick_ldr_s) begin
                  mem_addr_d  = ldr_addr;
                  mem_wdata_d = ldr_wdata;
                  ok_d        = 1'b1;
                  rd_d        = 1'b0;
                  mem_en_d    = 1'b1;
                  mem_we_d    = 1'b1;
               end else begin
                  mem_addr_d  = cpu_addr[ADDR_W+1:2];
                  mem_wdata_d = cpu_wdata;
                  ok_d        = cpu_ok_s;
                  rd_d        = cpu_ok_s & ~cpu_we;
                  mem_en_d    = cpu_ok_s;
                  mem_we_d    = cpu_ok_s & cpu_we;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d   = RESP;
            cpu_ack_d = ~gnt_ldr_q;
            ldr_ack_d = gnt_ldr_q;
            cpu_err_d = ~gnt_ldr_q & ~ok_q;
            if (rd_q) begin
               cpu_rdata_d = mem_rdata;
            end else begin
               cpu_rdata_d = cpu_rdata_q;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_ldr_q   <= 1'b0;
         last_ldr_q  <= 1'b1;
         ok_q        <= 1'b0;
         rd_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         cpu_ack_q   <= 1'b0;
         ldr_ack_q   <= 1'b0;
         cpu_err_q   <= 1'b0;
         cpu_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         gnt_ldr_q   <= gnt_ldr_d;
         last_ldr_q  <= last_ldr_d;
         ok_q        <= ok_d;
         rd_q        <= rd_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         ldr_ack_q   <= ldr_ack_d;
         cpu_err_q   <= cpu_err_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign ldr_ack   = ldr_ack_q;
   assign cpu_err   = cpu_err_q;
   assign cpu_rdata = cpu_rdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
   localparam int AW = 14;

   logic          clock = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, cpu_ack, cpu_err;
   logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
   logic          ldr_req, ldr_ack;
   logic [AW-1:0] ldr_addr;
   logic [31:0]   ldr_wdata;
   logic          mem_en, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   always #5 clock = ~clock;

   mem_arbiter #(.ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Data memory: operates on the falling edge so read data is ready by the next rising edge.
   logic [31:0] ram [0:(1<<AW)-1];
   bit          ram_init = 1'b0;
   always @(negedge clock) begin
      if (!ram_init) begin
         for (int i = 0; i < (1<<AW); i++) ram[i] <= 32'd0;
         mem_rdata <= 32'd0;
         ram_init  <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } op_t;

   op_t         cpu_q[$];
   op_t         ldr_q[$];
   logic [7:0]  grants[$];
   int          ldr_ack_k[$];
   bit          rand_en = 1'b0;
   int          nvec = 0;
   int          nbad = 0;

   // Reference model: a grant at edge k makes edge k the memory cycle, k+1 the ack, k+3 the next grant chance.
   logic [31:0] ref_mem [0:(1<<AW)-1];
   int          k = 0;
   int          start = -10;
   int          free_at = 0;
   bit          last_ldr = 1'b1;
   bit          cur_ldr, cur_ok, cur_we, cur_rd;
   logic [31:0] cur_addr, cur_wdata, pend_rd, exp_rdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
      end
   endtask

   task automatic model_edge();
      if (k == start + 1 && cur_rd) exp_rdata = pend_rd;
      if (k >= free_at && (cpu_req || ldr_req)) begin
         cur_ldr  = ldr_req && (!cpu_req || !last_ldr);
         last_ldr = cur_ldr;
         start    = k;
         free_at  = k + 3;
         if (cur_ldr) begin
            cur_ok = 1'b1; cur_we = 1'b1; cur_rd = 1'b0;
            cur_addr = 32'(ldr_addr); cur_wdata = ldr_wdata;
         end else begin
            cur_ok    = (cpu_addr < (32'd1 << (AW + 2))) && (cpu_addr % 32'd4 == 32'd0);
            cur_we    = cpu_we;
            cur_addr  = (cpu_addr / 32'd4) % (32'd1 << AW);
            cur_wdata = cpu_wdata;
            cur_rd    = cur_ok && !cpu_we;
         end
         if (cur_ok && cur_we) ref_mem[cur_addr[AW-1:0]] = cur_wdata;
         if (cur_rd) pend_rd = ref_mem[cur_addr[AW-1:0]];
      end
   endtask

   task automatic check_outputs();
      bit in_acc, in_resp;
      in_acc  = (k == start);
      in_resp = (k == start + 1);
      chk("busy", 32'(busy), 32'(in_acc || in_resp));
      chk("mem_en", 32'(mem_en), 32'(in_acc && cur_ok));
      if (in_acc && cur_ok) begin
         chk("mem_we", 32'(mem_we), 32'(cur_we));
         chk("mem_addr", 32'(mem_addr), cur_addr);
         chk("mem_wdata", mem_wdata, cur_wdata);
      end
      chk("cpu_ack", 32'(cpu_ack), 32'(in_resp && !cur_ldr));
      chk("ldr_ack", 32'(ldr_ack), 32'(in_resp && cur_ldr));
      chk("cpu_err", 32'(cpu_err), 32'(in_resp && !cur_ldr && !cur_ok));
      chk("cpu_rdata", cpu_rdata, exp_rdata);
      if (cpu_ack) grants.push_back(8'h43);
      if (ldr_ack) begin
         grants.push_back(8'h4C);
         ldr_ack_k.push_back(k);
      end
   endtask

   task automatic edge_check();
      @(posedge clock);
      k++;
      model_edge();
      #1;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_cpu_addr();
      case ($urandom_range(0, 9))
         0:       return 32'hFFFF_FC60;
         1:       return (32'($urandom_range(0, 15)) << 2) | 32'd1;
         2:       return 32'h0000_FFFC;
         3:       return 32'h0001_0000;
         default: return 32'($urandom_range(0, 15)) << 2;
      endcase
   endfunction

   task automatic drive();
      op_t op;
      if (cpu_req && cpu_ack) begin
         cpu_req = 1'b0;
      end else if (!cpu_req) begin
         if (cpu_q.size() > 0) begin
            op = cpu_q.pop_front();
            cpu_req = 1'b1; cpu_we = op.we; cpu_addr = op.addr; cpu_wdata = op.data;
         end else if (rand_en && $urandom_range(0, 2) == 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = rand_cpu_addr(); cpu_wdata = $urandom;
         end
      end
      if (ldr_req && ldr_ack) begin
         ldr_req = 1'b0;
      end else if (!ldr_req) begin
         if (ldr_q.size() > 0) begin
            op = ldr_q.pop_front();
            ldr_req = 1'b1; ldr_addr = op.addr[AW-1:0]; ldr_wdata = op.data;
         end else if (rand_en && $urandom_range(0, 3) == 0) begin
            ldr_req = 1'b1; ldr_wdata = $urandom;
            ldr_addr = ($urandom_range(0, 7) == 0) ? AW'((1 << AW) - 1) : AW'($urandom_range(0, 15));
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         edge_check();
         drive();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cpu_req = 1'b0; ldr_req = 1'b0;
      cpu_q.delete(); ldr_q.delete(); grants.delete(); ldr_ack_k.delete();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst_ldr_ack", 32'(ldr_ack), 32'd0);
      chk("rst_cpu_err", 32'(cpu_err), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      reset = 1'b0;
      start = -10; free_at = 0; last_ldr = 1'b1;
      exp_rdata = 32'd0; cur_rd = 1'b0;
   endtask

   initial begin
      logic [7:0]  exp_order [4];
      logic [31:0] saved;
      bit          seen;
      exp_order = '{8'h43, 8'h4C, 8'h43, 8'h4C};
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = 32'd0;
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 32'd0;
      do_reset();

      // CPU write then read of the same word
      cpu_q.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF});
      cpu_q.push_back('{1'b0, 32'h0000_0010, 32'd0});
      drive();
      run(10);
      chk("wr_rd_data", cpu_rdata, 32'hDEAD_BEEF);

      // Simultaneous requests held continuously alternate, CPU first
      do_reset();
      cpu_q.push_back('{1'b0, 32'h0000_0010, 32'd0});
      cpu_q.push_back('{1'b1, 32'h0000_0014, 32'h1234_5678});
      ldr_q.push_back('{1'b1, 32'd6, 32'hCAFE_0006});
      ldr_q.push_back('{1'b1, 32'd7, 32'hCAFE_0007});
      drive();
      run(14);
      chk("grant_count", 32'(grants.size()), 32'd4);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order", 32'(grants[i]), 32'(exp_order[i]));

      // Out-of-range, misaligned and just-past-the-end CPU accesses
      cpu_q.push_back('{1'b0, 32'hFFFF_FC60, 32'd0});
      cpu_q.push_back('{1'b1, 32'h0000_0012, 32'h0BAD_0BAD});
      cpu_q.push_back('{1'b0, 32'h0001_0000, 32'd0});
      cpu_q.push_back('{1'b0, 32'h0000_FFFC, 32'd0});
      drive();
      run(16);

      // Loader burst of four writes
      ldr_ack_k.delete();
      for (int i = 0; i < 4; i++) ldr_q.push_back('{1'b1, 32'(i), 32'h11 * 32'(i + 1)});
      drive();
      run(16);
      chk("burst_acks", 32'(ldr_ack_k.size()), 32'd4);
      for (int i = 1; i < ldr_ack_k.size(); i++) chk("burst_spacing", 32'(ldr_ack_k[i] - ldr_ack_k[i-1]), 32'd3);
      for (int i = 0; i < 4; i++) chk("burst_ram", ram[i], 32'h11 * 32'(i + 1));

      // Loader arrives while a CPU read is in its response cycle
      cpu_q.push_back('{1'b0, 32'h0000_0004, 32'd0});
      drive();
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         edge_check();
         if (cpu_ack) begin
            seen = 1'b1;
            ldr_q.push_back('{1'b1, 32'd5, 32'h0000_0055});
         end
         drive();
      end
      if (!seen) chk("pend_cpu_ack_seen", 32'd0, 32'd1);
      run(8);
      chk("pend_cpu_rdata", cpu_rdata, 32'h0000_0022);
      chk("pend_ldr_ram", ram[5], 32'h0000_0055);

      // Reset during the memory cycle of a CPU write
      saved = ref_mem[8];
      cpu_q.push_back('{1'b1, 32'h0000_0020, 32'hA5A5_5A5A});
      drive();
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         edge_check();
         if (mem_en) seen = 1'b1;
         else        drive();
      end
      if (!seen) chk("midrst_access_seen", 32'd0, 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_mem_en", 32'(mem_en), 32'd0);
      @(posedge clock);
      #1;
      chk("midrst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("midrst_busy2", 32'(busy), 32'd0);
      @(negedge clock);
      chk("midrst_no_write", ram[8], saved);
      ref_mem[8] = saved;
      do_reset();

      // Random traffic from both requesters
      rand_en = 1'b1;
      drive();
      run(600);
      rand_en = 1'b0;
      run(12);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, data-memory word-address width.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cpu_req  input  1  CPU data-access request, held until cpu_ack.
REQ-005 SHALL have port cpu_we  input  1  CPU write (1) or read (0), stable while cpu_req is high.
REQ-006 SHALL have port cpu_addr  input  32  CPU byte address; the word address is cpu_addr[ADDR_W+1:2].
REQ-007 SHALL have port cpu_wdata  input  32  CPU write data.
REQ-008 SHALL have port cpu_ack  output  1  one-cycle completion pulse to the CPU.
REQ-009 SHALL have port cpu_rdata  output  32  CPU read data, valid when cpu_ack is high.
REQ-010 SHALL have port cpu_err  output  1  one-cycle pulse with cpu_ack for an out-of-range address.
REQ-011 SHALL have port ldr_req  input  1  UART program-loader write request, held until ldr_ack.
REQ-012 SHALL have port ldr_addr  input  ADDR_W  loader word address.
REQ-013 SHALL have port ldr_wdata  input  32  loader write data (loader is write-only).
REQ-014 SHALL have port ldr_ack  output  1  one-cycle completion pulse to the loader.
REQ-015 SHALL have port mem_en  output  1  data-memory enable.
REQ-016 SHALL have port mem_we  output  1  data-memory write enable.
REQ-017 SHALL have port mem_addr  output  ADDR_W  data-memory word address.
REQ-018 SHALL have port mem_wdata  output  32  data-memory write data.
REQ-019 SHALL have port mem_rdata  input  32  data-memory read data, valid one cycle after the mem_en read cycle.
REQ-020 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-021 SHALL implement the FSM states IDLE, ACCESS and RESP with the sequence IDLE->ACCESS->RESP->IDLE; ACCESS and RESP each last exactly one cycle.
REQ-022 In IDLE with a request present, SHALL latch the winner's we, addr and wdata into mem_* registers and go to ACCESS; with no request, SHALL stay in IDLE.
REQ-023 SHALL arbitrate round-robin: when only one request is present, that request wins; when both are present, the requester not granted last wins; the last-grant pointer updates on each grant.
REQ-024 SHALL assert mem_en only in ACCESS, with mem_we=1 for a loader grant and mem_we=cpu_we for a CPU grant.
REQ-025 SHALL keep the previous values of mem_addr and mem_wdata outside ACCESS.
REQ-026 In RESP, SHALL pulse the granted requester's ack; for a CPU read, SHALL register mem_rdata into cpu_rdata on the ACCESS->RESP edge.
REQ-027 SHALL hold cpu_rdata until the next CPU read completes.
REQ-028 Latency SHALL be exactly 2 cycles from a req sampled in IDLE to ack high.
REQ-029 Requesters SHALL drop req in the cycle after ack; a req sampled high in IDLE is always a new request.
REQ-030 If a CPU request has cpu_addr[31:ADDR_W+2] != 0 or cpu_addr[1:0] != 0, SHALL still sequence ACCESS and RESP with mem_en held 0 and cpu_rdata unchanged, and SHALL pulse cpu_err with cpu_ack.
REQ-031 SHALL ignore the losing request during a transaction; that request remains pending and is served next.
REQ-032 SHALL assert busy combinationally from the state.

Reset
REQ-033 On reset, SHALL force IDLE with cpu_ack=0, ldr_ack=0, cpu_err=0, cpu_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 and busy=0.
REQ-034 On reset, SHALL set the last-grant pointer to loader, so the CPU wins the first tie.
REQ-035 Reset during ACCESS or RESP SHALL abort the transaction immediately; no ack SHALL be issued, and no write SHALL occur after reset asserts.

Verification
REQ-036 CPU write then read: write cpu_addr=0x0000_0010, cpu_wdata=0xDEADBEEF, then read the same address -> mem_addr=4 with mem_we=1 in ACCESS; the read returns cpu_rdata=0xDEADBEEF with cpu_ack 2 cycles after req.
REQ-037 Simultaneous requests after reset: both req high -> CPU granted first, loader granted second; with both held continuously, grants alternate CPU, LDR, CPU, LDR.
REQ-038 Out-of-range access: cpu_addr=0xFFFF_FC60 read -> mem_en stays 0, cpu_ack and cpu_err pulse together, cpu_rdata unchanged.
REQ-039 Loader burst: 4 writes to addresses 0..3 with data 0x11..0x44, no CPU traffic -> 4 ldr_ack pulses spaced 3 cycles apart, memory holds the data.
REQ-040 Reset mid-transaction: reset asserted during ACCESS of a CPU write -> next cycle busy=0 and mem_en=0, no cpu_ack, state IDLE.
REQ-041 Pending request: loader requests while a CPU read is in RESP -> loader is granted in the IDLE cycle that follows, and the CPU read completes unaffected.
